ext_razor_collector: RTL and testbench
======================================

Name: ext_razor_collector

Overview:
- Downstream stage of the extrinsic (be1) computation block in the FPTD datapath.
- Each cycle it accepts one registered extrinsic sample plus its Razor error flag, and corrects the flagged bit using the latch-captured value.
- It tags frame boundaries and buffers corrected samples in a small FIFO toward the interleaver/next half-iteration, with valid/ready handshake.
- It keeps per-frame Razor error statistics for the voltage/clock scaling controller.

Parameters:
- M, 6, extrinsic word width (two's complement).
- RazorBit, 1, Razor-monitored bit is index M-RazorBit of the sample.
- DEPTH, 8, FIFO entries (power of two, >=2).
- BLOCK_LEN, 64, samples per frame (>=2).
- CNT_W, 8, width of the error counter.
- ERR_TH, 4, per-frame error count at or above which err_frame_flag is set.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  be1_DFF/Error_current_be1 carry a new sample this cycle.
- be1_DFF  in  M  signed extrinsic sample from the extrinsic stage register.
- Error_current_be1  in  1  Razor mismatch on bit M-RazorBit of be1_DFF this cycle.
- in_ready  out  1  FIFO can accept a sample (= not full).
- out_valid  out  1  out_data/out_last hold the FIFO head.
- out_data  out  M  corrected signed extrinsic sample.
- out_last  out  1  head sample is the final sample of its frame.
- out_ready  in  1  consumer accepts the head this cycle.
- err_count  out  CNT_W  Razor error count of the most recently completed frame.
- err_frame_flag  out  1  err_count >= ERR_TH for the most recently completed frame.
- overflow  out  1  sticky: a sample arrived while in_ready was 0.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
- Reset state: FIFO empty, sample index 0, internal error counter 0.
- Outputs after reset: out_valid=0, out_data=0, out_last=0, err_count=0, err_frame_flag=0, overflow=0, in_ready=1.
- Reset asserted mid-frame or mid-transfer discards all buffered data and partial statistics. No sample is accepted in a cycle where Reset=1.
- Correction (combinational on input):
  - corrected = be1_DFF with bit M-RazorBit inverted when in_valid & Error_current_be1; otherwise be1_DFF unchanged.
  - Error_current_be1 is ignored when in_valid=0.
- Accept: a sample is accepted when in_valid & in_ready. The corrected word and last tag are written to the FIFO tail.
- Overflow: in_valid & !in_ready drops the sample and sets overflow=1. overflow is cleared only by Reset. The dropped sample does not advance the index or the counters.
- Frame index: increments on each accepted sample. The last tag is 1 when index==BLOCK_LEN-1; index then wraps to 0.
- Pop: when out_valid & out_ready the head is removed.
- out_data/out_last: come directly from FIFO head storage and stay stable while out_valid & !out_ready.
- Latency: a sample accepted at edge k is visible on out_valid/out_data after edge k (next cycle) when the FIFO was empty. There is no same-cycle bypass.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- Full: in_ready=0 when occupancy==DEPTH, even if out_ready=1 that cycle (no pass-through at full).
- Empty: out_valid=0; out_data holds its last value.
- Pointers: read/write pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Error counter:
  - Increments on each accepted sample with Error_current_be1=1, saturating at 2^CNT_W-1.
  - On acceptance of the last sample of a frame, err_count <= final count including that sample, and err_frame_flag <= (that count >= ERR_TH). The internal counter then restarts at 0.
  - Both outputs hold until the next frame end.
- Sign and width: no arithmetic beyond the bit flip; the corrected value stays M bits two's complement.

Test Plan:
- Single sample, no error: Reset, then in_valid=1, be1_DFF=6'b000011, Error=0 -> next cycle out_valid=1, out_data=6'b000011, out_last=0.
- Correction: be1_DFF=6'b000011, Error=1 (M=6, RazorBit=1, bit 5) -> out_data=6'b100011 (-29). Error=1 with in_valid=0 -> no FIFO write and no count change.
- Backpressure/full: out_ready=0, stream 10 valid samples 1..10 -> first 8 stored, in_ready=0 after the 8th, samples 9-10 dropped, overflow=1. Then out_ready=1 -> outputs 1..8 in order, each stable while stalled.
- Frame boundary: BLOCK_LEN=64, 64 accepted samples with errors on samples 3,10,20,40,63 -> out_last=1 only on the 64th output; err_count=5 and err_frame_flag=1 after the 64th acceptance. The next frame with 0 errors -> err_count=0, flag=0 at its end.
- Saturation: CNT_W=3, BLOCK_LEN=16, every sample errored -> err_count=7 at frame end, not 16.
- Reset mid-operation: 5 samples buffered, index=20, assert Reset one cycle -> out_valid=0, in_ready=1, overflow=0, err_count=0. The following frame needs a full 64 samples before out_last.

Source files
------------

// File: rtl/ext_razor_collector_if.sv
// Stream interface of the extrinsic Razor collector: the sample input side
// (valid/ready with Razor error flag) and the corrected-sample output side.
interface ext_razor_collector_if #(
  parameter int unsigned M = 6
) ();

  // Producer side (extrinsic stage register)
  logic         in_valid;
  logic [M-1:0] be1_DFF;
  logic         Error_current_be1;
  logic         in_ready;

  // Consumer side (interleaver / next half-iteration)
  logic         out_valid;
  logic [M-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  // Collector view
  modport slave (
    input  in_valid,
    input  be1_DFF,
    input  Error_current_be1,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  // Environment view: drives samples in and the consumer ready
  modport master (
    output in_valid,
    output be1_DFF,
    output Error_current_be1,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/ext_razor_collector.sv
// Razor collector downstream of the extrinsic (be1) stage: corrects the
// Razor-monitored bit, tags frame ends, buffers samples in a FIFO and keeps
// per-frame Razor error statistics for the voltage/clock scaling controller.
module ext_razor_collector #(
  parameter int unsigned M         = 6,
  parameter int unsigned RazorBit  = 1,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BLOCK_LEN = 64,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_TH    = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  ext_razor_collector_if.slave  bus,
  output logic [CNT_W-1:0]      err_count,
  output logic                  err_frame_flag,
  output logic                  overflow
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW       = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int unsigned RazorIdx = M - RazorBit;

  localparam logic [PW:0]   FullCnt = (PW + 1)'(DEPTH);
  localparam logic [IW-1:0] LastIdx = IW'(BLOCK_LEN - 1);

  // FIFO storage: {last tag, corrected sample}
  logic [M:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      occ_q, occ_d;

  // Value shown on the output while the FIFO is empty
  logic [M-1:0]     hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;

  // Frame position and error statistics
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_flag_q, err_flag_d;
  logic             overflow_q, overflow_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             is_last;
  logic [M-1:0]     flip_mask;
  logic [M-1:0]     corrected;
  logic [CNT_W-1:0] cnt_inc;
  logic [M:0]       head;

  // Handshake qualifiers and Razor correction of the incoming sample
  always_comb begin
    full      = (occ_q == FullCnt);
    empty     = (occ_q == '0);
    push      = bus.in_valid & ~full;
    pop       = ~empty & bus.out_ready;
    is_last   = (idx_q == LastIdx);
    flip_mask = '0;
    flip_mask[RazorIdx] = bus.in_valid & bus.Error_current_be1;
    corrected = bus.be1_DFF ^ flip_mask;
    head      = mem_q[rd_ptr_q];
    // Saturating increment of the running error count for this sample
    if (bus.Error_current_be1 && (cnt_q != '1)) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end else begin
      cnt_inc = cnt_q;
    end
  end

  // Next-state for pointers, occupancy and the empty-hold value
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      hold_data_d = head[M-1:0];
      hold_last_d = head[M];
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (PW + 1)'(1);
      2'b01:   occ_d = occ_q - (PW + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Next-state for frame index, error statistics and sticky overflow
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    overflow_d  = overflow_q;
    if (bus.in_valid && full) begin
      overflow_d = 1'b1;
    end
    if (push) begin
      if (is_last) begin
        idx_d       = '0;
        cnt_d       = '0;
        err_count_d = cnt_inc;
        err_flag_d  = (32'(cnt_inc) >= ERR_TH);
      end else begin
        idx_d = idx_q + IW'(1);
        cnt_d = cnt_inc;
      end
    end
  end

  // Control state; reset drops buffered data and partial frame statistics
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage write; contents are only visible through occupancy
  always_ff @(posedge Clock) begin
    if (!Reset && push) begin
      mem_q[wr_ptr_q] <= {is_last, corrected};
    end
  end

  // Outputs come straight from head storage while data is buffered
  always_comb begin
    bus.in_ready  = ~full;
    bus.out_valid = ~empty;
    bus.out_data  = empty ? hold_data_q : head[M-1:0];
    bus.out_last  = empty ? hold_last_q : head[M];
    err_count      = err_count_q;
    err_frame_flag = err_flag_q;
    overflow       = overflow_q;
  end

endmodule

// File: tb/tb_ext_razor_collector.sv
// Self-checking bench for ext_razor_collector: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_ext_razor_collector;

  localparam int unsigned M         = 6;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned BLOCK_LEN = 64;
  localparam int unsigned ERR_TH    = 4;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  ext_razor_collector_if #(.M(M)) bus ();
  ext_razor_collector_if #(.M(M)) bus2 ();

  logic [7:0] err_count;
  logic       err_frame_flag;
  logic       overflow;
  logic [2:0] err_count2;
  logic       err_frame_flag2;
  logic       overflow2;

  ext_razor_collector #(
    .M(M), .RazorBit(1), .DEPTH(DEPTH), .BLOCK_LEN(BLOCK_LEN), .CNT_W(8), .ERR_TH(ERR_TH)
  ) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus),
    .err_count(err_count), .err_frame_flag(err_frame_flag), .overflow(overflow)
  );

  // Short-frame, narrow-counter instance for the saturation scenario
  ext_razor_collector #(
    .M(M), .RazorBit(1), .DEPTH(DEPTH), .BLOCK_LEN(16), .CNT_W(3), .ERR_TH(ERR_TH)
  ) dut_sat (
    .Clock(Clock), .Reset(Reset), .bus(bus2),
    .err_count(err_count2), .err_frame_flag(err_frame_flag2), .overflow(overflow2)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: expected FIFO contents as {last, data}, frame statistics
  logic [6:0] exp_q[$];
  logic [5:0] hold_data;
  logic       hold_last;
  int         mdl_idx;
  int         mdl_cnt;
  int         mdl_err;
  bit         mdl_flag;
  bit         mdl_ovf;

  task automatic model_reset();
    exp_q.delete();
    hold_data = '0;
    hold_last = 1'b0;
    mdl_idx   = 0;
    mdl_cnt   = 0;
    mdl_err   = 0;
    mdl_flag  = 1'b0;
    mdl_ovf   = 1'b0;
  endtask

  // One clock of stimulus on the main instance, with the model advanced alongside
  task automatic step(input logic v, input logic [5:0] d, input logic e, input logic r);
    int         occ;
    bit         acc;
    bit         pp;
    bit         lst;
    logic [5:0] cd;
    bus.in_valid          = v;
    bus.be1_DFF           = d;
    bus.Error_current_be1 = e;
    bus.out_ready         = r;
    occ = exp_q.size();
    acc = v && (occ < DEPTH);
    pp  = (occ > 0) && r;
    cd  = (v && e) ? (d ^ 6'd32) : d;
    lst = (mdl_idx == BLOCK_LEN - 1);
    @(posedge Clock);
    #1;
    if (pp) {hold_last, hold_data} = exp_q.pop_front();
    if (acc) begin
      exp_q.push_back({lst, cd});
      mdl_idx = (mdl_idx + 1) % BLOCK_LEN;
      if (e) mdl_cnt = (mdl_cnt + 1 > 255) ? 255 : mdl_cnt + 1;
      if (lst) begin
        mdl_err  = mdl_cnt;
        mdl_flag = (mdl_cnt >= ERR_TH);
        mdl_cnt  = 0;
      end
    end
    if (v && !acc) mdl_ovf = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  // Single-cycle reset; v drives a sample during reset that must not be taken
  task automatic do_reset(input logic v);
    Reset                  = 1'b1;
    bus.in_valid           = v;
    bus.be1_DFF            = 6'h15;
    bus.Error_current_be1  = 1'b1;
    bus.out_ready          = 1'b0;
    bus2.in_valid          = 1'b0;
    bus2.be1_DFF           = '0;
    bus2.Error_current_be1 = 1'b0;
    bus2.out_ready         = 1'b1;
    @(posedge Clock);
    #1;
    Reset        = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !== {1'b0, 6'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b rdy=%b, expected v=0 d=00 l=0 rdy=1",
               bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
    end
    vectors++;
    if ({err_count, err_frame_flag, overflow} !== {8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_stats: got cnt=%0d flag=%b ovf=%b, expected 0 0 0",
               err_count, err_frame_flag, overflow);
    end
    vectors++;
    if ({bus2.out_valid, bus2.in_ready, err_count2} !== {1'b0, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_sat_inst: got v=%b rdy=%b cnt=%0d, expected 0 1 0",
               bus2.out_valid, bus2.in_ready, err_count2);
    end
  endtask

  task automatic test_single();
    do_reset(1'b0);
    step(1'b1, 6'b000011, 1'b0, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 6'b000011, 1'b0}) begin
      miscompares++;
      $display("FAIL single_sample: got v=%b d=%b l=%b, expected v=1 d=000011 l=0",
               bus.out_valid, bus.out_data, bus.out_last);
    end
    step(1'b0, 6'd0, 1'b0, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.out_data} !== {1'b0, 6'b000011}) begin
      miscompares++;
      $display("FAIL empty_hold: got v=%b d=%b, expected v=0 d=000011",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_correction();
    do_reset(1'b0);
    step(1'b1, 6'b000011, 1'b1, 1'b0);
    vectors++;
    if (bus.out_data !== 6'b100011 || $signed(bus.out_data) != -29) begin
      miscompares++;
      $display("FAIL correction: got d=%b (%0d), expected 100011 (-29)",
               bus.out_data, $signed(bus.out_data));
    end
    // Error flag without valid: pop the head, nothing new may appear
    step(1'b0, 6'h3F, 1'b1, 1'b1);
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL err_without_valid: got v=%b rdy=%b, expected v=0 rdy=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 6'(i), 1'b0, 1'b0);
      vectors++;
      if (bus.in_ready !== (i < 8) || overflow !== (i > 8)) begin
        miscompares++;
        $display("FAIL fill_%0d: got rdy=%b ovf=%b, expected rdy=%b ovf=%b",
                 i, bus.in_ready, overflow, (i < 8), (i > 8));
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 6'd0, 1'b0, 1'b0);
      vectors++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 6'(k)}) begin
        miscompares++;
        $display("FAIL stall_head_%0d: got v=%b d=%0d, expected v=1 d=%0d",
                 k, bus.out_valid, bus.out_data, k);
      end
      step(1'b0, 6'd0, 1'b0, 1'b1);
    end
    vectors++;
    if ({bus.out_valid, bus.in_ready, overflow} !== 3'b011) begin
      miscompares++;
      $display("FAIL drained: got v=%b rdy=%b ovf=%b, expected v=0 rdy=1 ovf=1",
               bus.out_valid, bus.in_ready, overflow);
    end
  endtask

  task automatic test_frame();
    logic e;
    do_reset(1'b0);
    for (int i = 1; i <= 64; i++) begin
      e = (i == 3) || (i == 10) || (i == 20) || (i == 40) || (i == 63);
      step(1'b1, 6'(i), e, 1'b1);
      vectors++;
      if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, (i == 64), exp_q[0][5:0]}) begin
        miscompares++;
        $display("FAIL frame1_out_%0d: got v=%b l=%b d=%h, expected v=1 l=%b d=%h",
                 i, bus.out_valid, bus.out_last, bus.out_data, (i == 64), exp_q[0][5:0]);
      end
      if (i >= 63) begin
        vectors++;
        if ({err_count, err_frame_flag} !== ((i == 64) ? {8'd5, 1'b1} : {8'd0, 1'b0})) begin
          miscompares++;
          $display("FAIL frame1_stats_%0d: got cnt=%0d flag=%b, expected cnt=%0d flag=%b",
                   i, err_count, err_frame_flag, (i == 64) ? 5 : 0, (i == 64));
        end
      end
    end
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 6'($urandom), 1'b0, 1'b1);
      if (i == 63 || i == 64) begin
        vectors++;
        if ({err_count, err_frame_flag, bus.out_last} !==
            ((i == 64) ? {8'd0, 1'b0, 1'b1} : {8'd5, 1'b1, 1'b0})) begin
          miscompares++;
          $display("FAIL frame2_%0d: got cnt=%0d flag=%b l=%b", i, err_count, err_frame_flag,
                   bus.out_last);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    exp_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      bus2.in_valid          = 1'b1;
      bus2.be1_DFF           = 6'(i);
      bus2.Error_current_be1 = 1'b1;
      bus2.out_ready         = 1'b1;
      @(posedge Clock);
      #1;
      exp_cnt = (exp_cnt + 1 > 7) ? 7 : exp_cnt + 1;
      vectors++;
      if (bus2.out_last !== (i == 16)) begin
        miscompares++;
        $display("FAIL sat_last_%0d: got %b expected %b", i, bus2.out_last, (i == 16));
      end
    end
    bus2.in_valid = 1'b0;
    vectors++;
    if ({err_count2, err_frame_flag2} !== {3'(exp_cnt), (exp_cnt >= ERR_TH)}) begin
      miscompares++;
      $display("FAIL saturation: got cnt=%0d flag=%b, expected cnt=%0d flag=%b",
               err_count2, err_frame_flag2, exp_cnt, (exp_cnt >= ERR_TH));
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 6'(i), 1'b1, 1'b1);
    step(1'b0, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 6'(i), 1'b1, 1'b0);
    vectors++;
    if ({bus.out_valid, bus.in_ready, overflow} !== 3'b101) begin
      miscompares++;
      $display("FAIL pre_reset: got v=%b rdy=%b ovf=%b, expected 1 0 1",
               bus.out_valid, bus.in_ready, overflow);
    end
    do_reset(1'b1);
    vectors++;
    if ({bus.out_valid, bus.in_ready, overflow, err_count} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b rdy=%b ovf=%b cnt=%0d, expected 0 1 0 0",
               bus.out_valid, bus.in_ready, overflow, err_count);
    end
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 6'(i), 1'b0, 1'b1);
      vectors++;
      if (bus.out_last !== (i == 64)) begin
        miscompares++;
        $display("FAIL post_reset_last_%0d: got %b expected %b", i, bus.out_last, (i == 64));
      end
    end
    vectors++;
    if ({err_count, err_frame_flag} !== {8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL post_reset_stats: got cnt=%0d flag=%b, expected 0 0",
               err_count, err_frame_flag);
    end
  endtask

  task automatic test_random();
    logic v, e, r;
    logic [6:0] exp_head;
    do_reset(1'b0);
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 3) == 0);
      r = (n < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      step(v, 6'($urandom), e, r);
      exp_head = (exp_q.size() > 0) ? exp_q[0] : {hold_last, hold_data};
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.out_last, bus.out_data} !==
          {(exp_q.size() > 0), (exp_q.size() < DEPTH), exp_head}) begin
        miscompares++;
        $display("FAIL rand_stream_%0d: got v=%b rdy=%b l=%b d=%h, expected v=%b rdy=%b l=%b d=%h",
                 n, bus.out_valid, bus.in_ready, bus.out_last, bus.out_data,
                 (exp_q.size() > 0), (exp_q.size() < DEPTH), exp_head[6], exp_head[5:0]);
      end
      vectors++;
      if ({err_count, err_frame_flag, overflow} !== {8'(mdl_err), mdl_flag, mdl_ovf}) begin
        miscompares++;
        $display("FAIL rand_stats_%0d: got cnt=%0d flag=%b ovf=%b, expected cnt=%0d flag=%b ovf=%b",
                 n, err_count, err_frame_flag, overflow, mdl_err, mdl_flag, mdl_ovf);
      end
    end
  endtask

  initial begin
    Reset                  = 1'b1;
    bus.in_valid           = 1'b0;
    bus.be1_DFF            = '0;
    bus.Error_current_be1  = 1'b0;
    bus.out_ready          = 1'b0;
    bus2.in_valid          = 1'b0;
    bus2.be1_DFF           = '0;
    bus2.Error_current_be1 = 1'b0;
    bus2.out_ready         = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    test_reset();
    test_single();
    test_correction();
    test_backpressure();
    test_frame();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
